// File: rtl/exu_ctrl_pkg.sv
// Shared types and constants for the execute-stage sequencing controller.
package exu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL      = 3'd1,
    ST_LSU_REQ  = 3'd2,
    ST_LSU_WAIT = 3'd3,
    ST_DONE     = 3'd4,
    ST_DRAIN    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_MUL = 2'd1,
    CLS_MEM = 2'd2
  } cls_e;

  localparam int MUL_CYCLES_MAX = 16;
  localparam int MUL_CNT_W      = $clog2(MUL_CYCLES_MAX);

  // Memory class wins when both class flags are set.
  function automatic cls_e decode_class(input logic is_mem, input logic is_mul);
    if (is_mem)      return CLS_MEM;
    else if (is_mul) return CLS_MUL;
    else             return CLS_ALU;
  endfunction

endpackage

// File: rtl/exu_mul_timer.sv
// Loadable down-counter with zero flag, timing the MUL occupancy of the stage.
module exu_mul_timer
  import exu_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [MUL_CNT_W-1:0] load_val_i,
  input  logic                 dec_i,
  input  logic                 clr_i,
  output logic                 zero_o
);

  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - MUL_CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/exu_ctrl.sv
// Execute-stage sequencer: accepts from IDU, times ALU/MUL/LSU work, hands results to WBU.
module exu_ctrl
  import exu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idu_valid_i,
  output logic             exu_ready_o,
  input  logic             is_mem_i,
  input  logic             is_mul_i,
  output logic             we_o,
  output logic             lsu_req_valid_o,
  input  logic             lsu_req_ready_i,
  input  logic             lsu_resp_valid_i,
  output logic             wbu_valid_o,
  input  logic             wbu_ready_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cls_e   cls;
  state_e accept_state;
  logic   ready, accept, req_vld, wbu_vld, retire;
  logic   tmr_load, tmr_dec, tmr_clr, tmr_zero;

  always_comb begin
    cls    = decode_class(is_mem_i, is_mul_i);
    ready  = !flush_i && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && wbu_ready_i));
    accept = idu_valid_i && ready;
    case (cls)
      CLS_MEM: accept_state = ST_LSU_REQ;
      CLS_MUL: accept_state = ST_MUL;
      default: accept_state = ST_DONE;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_vld  = 1'b0;
    wbu_vld  = 1'b0;
    retire   = 1'b0;
    tmr_load = accept && (cls == CLS_MUL);
    tmr_dec  = 1'b0;
    tmr_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          tmr_clr = 1'b1;
        end else if (accept) begin
          state_d = accept_state;
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_LSU_REQ: begin
        // A request already taken by the LSU must still be drained after a flush.
        req_vld = !(flush_i && !lsu_req_ready_i);
        if (flush_i)
          state_d = lsu_req_ready_i ? ST_DRAIN : ST_IDLE;
        else if (lsu_req_ready_i)
          state_d = ST_LSU_WAIT;
      end
      ST_LSU_WAIT: begin
        if (flush_i)
          state_d = lsu_resp_valid_i ? ST_IDLE : ST_DRAIN;
        else if (lsu_resp_valid_i)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        if (flush_i) begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end else begin
          wbu_vld = 1'b1;
          if (wbu_ready_i) begin
            retire  = 1'b1;
            state_d = accept ? accept_state : ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (lsu_resp_valid_i)
          state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  exu_mul_timer u_mul_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (MUL_CNT_W'(MUL_CYCLES - 1)),
    .dec_i      (tmr_dec),
    .clr_i      (tmr_clr),
    .zero_o     (tmr_zero)
  );

  // Every output reads zero for as long as reset is held.
  assign exu_ready_o     = !reset && ready;
  assign we_o            = !reset && accept;
  assign lsu_req_valid_o = !reset && req_vld;
  assign wbu_valid_o     = !reset && wbu_vld;
  assign busy_o          = !reset && (state_q != ST_IDLE);
  assign retired_cnt_o   = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_exu_ctrl.sv
// Directed-vector bench for exu_ctrl with hand-computed expectations (MUL_CYCLES=4).
module tb_exu_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        idu_valid_i, is_mem_i, is_mul_i;
  logic        lsu_req_ready_i, lsu_resp_valid_i, wbu_ready_i, flush_i;
  logic        exu_ready_o, we_o, lsu_req_valid_o, wbu_valid_o, busy_o;
  logic [31:0] retired_cnt_o;

  int n_vec = 0;
  int n_mis = 0;

  exu_ctrl #(.MUL_CYCLES(4), .CNT_W(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .idu_valid_i      (idu_valid_i),
    .exu_ready_o      (exu_ready_o),
    .is_mem_i         (is_mem_i),
    .is_mul_i         (is_mul_i),
    .we_o             (we_o),
    .lsu_req_valid_o  (lsu_req_valid_o),
    .lsu_req_ready_i  (lsu_req_ready_i),
    .lsu_resp_valid_i (lsu_resp_valid_i),
    .wbu_valid_o      (wbu_valid_o),
    .wbu_ready_i      (wbu_ready_i),
    .flush_i          (flush_i),
    .busy_o           (busy_o),
    .retired_cnt_o    (retired_cnt_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idu_valid_i = 0; is_mem_i = 0; is_mul_i = 0;
    lsu_req_ready_i = 0; lsu_resp_valid_i = 0; wbu_ready_i = 0; flush_i = 0;
    tick(); tick();

    // Reset holds every output low even with a valid instruction offered
    idu_valid_i = 1; wbu_ready_i = 1;
    #1;
    chk("rst_we", we_o, 0);
    chk("rst_ready", exu_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", retired_cnt_o, 0);
    idu_valid_i = 0; wbu_ready_i = 0; reset = 0;
    tick();

    // Single ALU op
    idu_valid_i = 1;
    #1;
    chk("alu_ready", exu_ready_o, 1);
    chk("alu_we", we_o, 1);
    tick();
    idu_valid_i = 0;
    #1;
    chk("alu_wbv", wbu_valid_o, 1);
    chk("alu_busy", busy_o, 1);
    chk("alu_notready", exu_ready_o, 0);
    wbu_ready_i = 1;
    #1;
    chk("alu_done_ready", exu_ready_o, 1);
    chk("alu_done_we", we_o, 0);
    tick();
    wbu_ready_i = 0;
    #1;
    chk("alu_cnt", retired_cnt_o, 1);
    chk("alu_idle", busy_o, 0);

    // MUL: accept at cycle 0, busy cycles 1..4, result at cycle 5
    idu_valid_i = 1; is_mul_i = 1;
    #1;
    chk("mul_we", we_o, 1);
    tick();
    idu_valid_i = 0; is_mul_i = 0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("mul_busy", busy_o, 1);
      chk("mul_notready", exu_ready_o, 0);
      chk("mul_nowbv", wbu_valid_o, 0);
      tick();
    end
    chk("mul_wbv", wbu_valid_o, 1);
    wbu_ready_i = 1;
    tick();
    wbu_ready_i = 0;
    #1;
    chk("mul_cnt", retired_cnt_o, 2);

    // LSU with 3 cycles of request backpressure and a stray early response
    idu_valid_i = 1; is_mem_i = 1;
    #1;
    chk("lsu_we", we_o, 1);
    tick();
    idu_valid_i = 0; is_mem_i = 0;
    for (int c = 0; c < 3; c++) begin
      lsu_resp_valid_i = (c == 0);
      #1;
      chk("lsu_req_hold", lsu_req_valid_o, 1);
      tick();
    end
    lsu_resp_valid_i = 0;
    lsu_req_ready_i = 1;
    #1;
    chk("lsu_req_hs", lsu_req_valid_o, 1);
    tick();
    lsu_req_ready_i = 0;
    #1;
    chk("lsu_wait_noreq", lsu_req_valid_o, 0);
    chk("lsu_wait_nowbv", wbu_valid_o, 0);
    tick();
    lsu_resp_valid_i = 1;
    #1;
    chk("lsu_resp_nowbv", wbu_valid_o, 0);
    tick();
    lsu_resp_valid_i = 0;
    #1;
    chk("lsu_wbv", wbu_valid_o, 1);
    wbu_ready_i = 1;
    tick();
    wbu_ready_i = 0;
    #1;
    chk("lsu_cnt", retired_cnt_o, 3);

    // Back-to-back ALU with a two-cycle WBU stall
    idu_valid_i = 1;
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("b2b_wbv_hold", wbu_valid_o, 1);
      chk("b2b_notready", exu_ready_o, 0);
      chk("b2b_nowe", we_o, 0);
      tick();
    end
    wbu_ready_i = 1;
    #1;
    chk("b2b_ready", exu_ready_o, 1);
    chk("b2b_we", we_o, 1);
    tick();
    idu_valid_i = 0; wbu_ready_i = 0;
    #1;
    chk("b2b_wbv2", wbu_valid_o, 1);
    chk("b2b_cnt1", retired_cnt_o, 4);
    wbu_ready_i = 1;
    tick();
    wbu_ready_i = 0;
    #1;
    chk("b2b_cnt2", retired_cnt_o, 5);
    chk("b2b_idle", busy_o, 0);

    // Flush in MUL with counter at 2
    idu_valid_i = 1; is_mul_i = 1;
    tick();
    idu_valid_i = 0; is_mul_i = 0;
    tick();
    flush_i = 1;
    #1;
    chk("fmul_notready", exu_ready_o, 0);
    tick();
    flush_i = 0;
    #1;
    chk("fmul_idle", busy_o, 0);
    tick(); tick(); tick(); tick();
    chk("fmul_nowbv", wbu_valid_o, 0);
    chk("fmul_cnt", retired_cnt_o, 5);

    // Flush in LSU_WAIT drains the outstanding response
    idu_valid_i = 1; is_mem_i = 1;
    tick();
    idu_valid_i = 0; is_mem_i = 0; lsu_req_ready_i = 1;
    tick();
    lsu_req_ready_i = 0; flush_i = 1;
    #1;
    chk("fwait_notready", exu_ready_o, 0);
    tick();
    idu_valid_i = 1;
    #1;
    chk("drain_busy", busy_o, 1);
    chk("drain_notready", exu_ready_o, 0);
    chk("drain_nowe", we_o, 0);
    tick();
    flush_i = 0;
    idu_valid_i = 0; lsu_resp_valid_i = 1;
    #1;
    chk("drain_nowbv", wbu_valid_o, 0);
    chk("drain_resp_notready", exu_ready_o, 0);
    tick();
    lsu_resp_valid_i = 0;
    #1;
    chk("drain_idle", busy_o, 0);
    chk("drain_cnt", retired_cnt_o, 5);

    // Flush in LSU_REQ without request handshake drops the request
    idu_valid_i = 1; is_mem_i = 1;
    tick();
    idu_valid_i = 0; is_mem_i = 0; flush_i = 1;
    #1;
    chk("freq_noreq", lsu_req_valid_o, 0);
    tick();
    flush_i = 0;
    #1;
    chk("freq_idle", busy_o, 0);

    // Flush coincident with WBU ready in DONE: no retire
    idu_valid_i = 1;
    tick();
    idu_valid_i = 0; wbu_ready_i = 1; flush_i = 1;
    #1;
    chk("fdone_nowbv", wbu_valid_o, 0);
    chk("fdone_notready", exu_ready_o, 0);
    tick();
    wbu_ready_i = 0; flush_i = 0;
    #1;
    chk("fdone_cnt", retired_cnt_o, 5);
    chk("fdone_idle", busy_o, 0);

    // Reset in LSU_WAIT, then a late response is ignored
    idu_valid_i = 1; is_mem_i = 1;
    tick();
    idu_valid_i = 0; is_mem_i = 0; lsu_req_ready_i = 1;
    tick();
    lsu_req_ready_i = 0;
    #1;
    chk("mrst_pre_busy", busy_o, 1);
    reset = 1; idu_valid_i = 1; wbu_ready_i = 1;
    #1;
    chk("mrst_we", we_o, 0);
    chk("mrst_ready", exu_ready_o, 0);
    chk("mrst_req", lsu_req_valid_o, 0);
    chk("mrst_wbv", wbu_valid_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_cnt", retired_cnt_o, 0);
    tick();
    reset = 0; idu_valid_i = 0; wbu_ready_i = 0;
    #1;
    chk("mrst_idle", busy_o, 0);
    chk("mrst_cnt_after", retired_cnt_o, 0);
    lsu_resp_valid_i = 1;
    tick();
    lsu_resp_valid_i = 0;
    #1;
    chk("mrst_late_busy", busy_o, 0);
    chk("mrst_late_wbv", wbu_valid_o, 0);
    chk("mrst_late_ready", exu_ready_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
